// File: rtl/or_pkg.sv
// Shared types and defaults for the OR-gate input debouncer.
package or_pkg;

  localparam int unsigned STABLE_CYCLES_DEF = 4;
  localparam int unsigned CNT_W_DEF         = 3;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_e;

endpackage : or_pkg

// File: rtl/debounce_chan.sv
// One debounced channel: 2-flop synchronizer, qualification FSM and counter,
// registered clean level plus one-cycle rise/fall event pulses.
module debounce_chan
  import or_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Reject parameter sets the counter cannot represent.
  if (STABLE_CYCLES < 2 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_param
    $error("debounce_chan: STABLE_CYCLES out of range for CNT_W");
  end

  logic             s1_q;
  logic             s2_q;
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             db_q;
  logic             db_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;

  logic sync;
  logic differ;
  logic qualified;

  assign sync      = s2_q;
  assign differ    = (sync != db_q);
  assign qualified = (state_q == ST_CHECK) && differ && (cnt_q == CNT_LAST);

  // Two-flop synchronizer for the asynchronous raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // FSM state and stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: count consecutive differing samples, restart on any bounce back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_STABLE: begin
        if (differ) begin
          state_d = ST_CHECK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_CHECK: begin
        if (!differ || (cnt_q == CNT_LAST)) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next values: adopt the new level and flag its direction once qualified.
  always_comb begin
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (qualified) begin
      db_d   = sync;
      rise_d = sync;
      fall_d = ~sync;
    end
  end

  // Registered level and event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule : debounce_chan

// File: rtl/or_input_debouncer.sv
// Two independent debounced channels feeding the a/B inputs of the OR gate.
module or_input_debouncer
  import or_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_db,
  output logic b_db,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  debounce_chan #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chan_a (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (a_raw),
    .db_o   (a_db),
    .rise_o (a_rise),
    .fall_o (a_fall)
  );

  debounce_chan #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chan_b (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (b_raw),
    .db_o   (b_db),
    .rise_o (b_rise),
    .fall_o (b_fall)
  );

endmodule : or_input_debouncer
